// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: FIFO-buffered word feeder for uart_frame_tx.
// Accepts FRAME_WD-bit words on a valid/ready stream and issues one frame_en
// pulse per word. It then holds data_frame until tx_done and can add an
// optional idle gap after each frame.
// Optional feature: define UART_TX_FEED_TIMEOUT_EN to bound the wait for
// tx_done. The timeout sets the sticky timeout_err flag and drops the word.
module uart_tx_feeder #(
    parameter int unsigned FRAME_WD    = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned GAP_CYC     = 0,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [FRAME_WD-1:0]        in_data,
    output logic                       in_ready,
    output logic                       frame_en,
    output logic [FRAME_WD-1:0]        data_frame,
    input  logic                       tx_done,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     level
`ifdef UART_TX_FEED_TIMEOUT_EN
    ,
    output logic                       timeout_err
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DONE,
        GAP
    } state_t;

    logic [FRAME_WD-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                push;
    logic                pop;

    state_t              state;
    state_t              state_nxt;
    logic                frame_en_nxt;
    logic [FRAME_WD-1:0] data_nxt;
    logic [GW-1:0]       gap_cnt;
    logic [GW-1:0]       gap_nxt;

`ifdef UART_TX_FEED_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0]       to_cnt;
    logic [TW-1:0]       to_nxt;
    logic                terr_nxt;
`endif

    assign in_ready = (level != FULL_LVL) && !rst;
    assign push     = in_valid && in_ready;
    assign busy     = (state != IDLE) || (level != '0);

    // FIFO storage write; contents need no reset because level gates reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            frame_en   <= 1'b0;
            data_frame <= '0;
            gap_cnt    <= '0;
`ifdef UART_TX_FEED_TIMEOUT_EN
            to_cnt      <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            frame_en   <= frame_en_nxt;
            data_frame <= data_nxt;
            gap_cnt    <= gap_nxt;
`ifdef UART_TX_FEED_TIMEOUT_EN
            to_cnt      <= to_nxt;
            timeout_err <= terr_nxt;
`endif
        end
    end

    // Next-state logic: pop the head in IDLE, wait for tx_done, then optional gap
    always_comb begin
        state_nxt    = state;
        frame_en_nxt = 1'b0;
        data_nxt     = data_frame;
        gap_nxt      = gap_cnt;
        pop          = 1'b0;
`ifdef UART_TX_FEED_TIMEOUT_EN
        to_nxt       = '0;
        terr_nxt     = timeout_err;
`endif
        case (state)
            IDLE: begin
                if (level != '0) begin
                    frame_en_nxt = 1'b1;
                    data_nxt     = mem[rd_ptr];
                    pop          = 1'b1;
                    state_nxt    = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    if (GAP_CYC > 0) begin
                        state_nxt = GAP;
                        gap_nxt   = GW'(1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
`ifdef UART_TX_FEED_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    terr_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    to_nxt = to_cnt + TW'(1);
                end
`endif
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt + GW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: the stimulus side queues accepted words.
// An independent monitor pops them on frame_en. A second instance with an
// idle gap is exercised with directed timing.
module tb_uart_tx_feeder;

    localparam int D  = 16;
    localparam int TO = 100;

    logic       clk;
    logic       rst, in_valid, in_ready, frame_en, tx_done, busy;
    logic [7:0] in_data, data_frame;
    logic [4:0] level;
    logic       g_rst, g_in_valid, g_in_ready, g_frame_en, g_tx_done, g_busy;
    logic [7:0] g_in_data, g_data_frame;
    logic [2:0] g_level;
`ifdef UART_TX_FEED_TIMEOUT_EN
    logic       timeout_err, g_timeout_err;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         acc_cnt = 0;
    int         pend = 0;
    bit         mon_en = 0;
    int         clr_req = 0;
    int         done_req = 0;
    bit         tx_auto = 1;
    bit         tx_fixed = 0;

    uart_tx_feeder #(.FRAME_WD(8), .DEPTH(D), .GAP_CYC(0), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .frame_en(frame_en), .data_frame(data_frame), .tx_done(tx_done), .busy(busy), .level(level)
`ifdef UART_TX_FEED_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    uart_tx_feeder #(.FRAME_WD(8), .DEPTH(4), .GAP_CYC(5), .TIMEOUT_CYC(TO)) dut_gap (
        .clk(clk), .rst(g_rst), .in_valid(g_in_valid), .in_data(g_in_data), .in_ready(g_in_ready),
        .frame_en(g_frame_en), .data_frame(g_data_frame), .tx_done(g_tx_done), .busy(g_busy), .level(g_level)
`ifdef UART_TX_FEED_TIMEOUT_EN
        , .timeout_err(g_timeout_err)
`endif
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; an accepted word is queued as an expected frame
    task automatic cyc(input bit v, input logic [7:0] d, input bit r);
        @(posedge clk);
        #1;
        in_valid = v;
        in_data  = d;
        rst      = r;
        #1;
        if (v && in_ready) begin
            exp_q.push_back(d);
            acc_cnt++;
            pend = 1;
        end else begin
            pend = 0;
        end
    endtask

    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        do begin
            cyc(1, d, 0);
            n++;
        end while (pend == 0 && n < 300);
        chk("send_accepted", pend, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 3000) begin
            cyc(0, 8'h00, 0);
            n++;
        end
        chk("drain_idle", busy, 0);
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    task automatic g_cyc(input bit v, input logic [7:0] d, input bit done);
        @(posedge clk);
        #1;
        g_rst      = 0;
        g_in_valid = v;
        g_in_data  = d;
        g_tx_done  = done;
        #1;
    endtask

    // Transmitter model: answers each frame after a delay; also injects requested pulses
    initial begin
        int cnt;
        bit owed;
        int seen;
        cnt = 0; owed = 0; seen = 0;
        tx_done = 0;
        forever begin
            @(negedge clk);
            #1;
            tx_done = 0;
            if (rst) begin
                owed = 0;
            end else begin
                if (frame_en) begin
                    owed = 1;
                    cnt  = tx_fixed ? 10 : int'($urandom_range(0, 10));
                end
                if (done_req != seen) begin
                    seen    = done_req;
                    tx_done = 1;
                    owed    = 0;
                end else if (owed && tx_auto) begin
                    if (cnt == 0) begin
                        tx_done = 1;
                        owed    = 0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // Monitor: checks frames in order, timing rules, level, busy and in_ready
    initial begin
        bit         outst, want, fe, idle_c, terr;
        logic [7:0] hold;
        int         issued, lvl_exp, age, clr_seen;
        outst = 0; want = 0; terr = 0; hold = 0;
        issued = 0; age = 0; clr_seen = 0;
        forever begin
            @(negedge clk);
            #4;
            if (clr_req != clr_seen) begin
                clr_seen = clr_req;
                outst = 0; want = 0; issued = 0; age = 0; terr = 0;
            end
            if (mon_en) begin
                fe = frame_en;
                chk("frame_en_timing", fe, want);
                if (fe) begin
                    if (exp_q.size() == 0) chk("frame_has_word", 0, 1);
                    else chk("frame_data", data_frame, exp_q.pop_front());
                    issued++;
                    hold = data_frame;
                end else if (outst) begin
                    chk("data_hold", data_frame, hold);
                end
                lvl_exp = acc_cnt - pend - issued;
                chk("level", level, lvl_exp);
                idle_c = !outst && !fe;
                chk("busy", busy, (!idle_c || lvl_exp > 0));
                chk("in_ready", in_ready, (lvl_exp < D) && !rst);
`ifdef UART_TX_FEED_TIMEOUT_EN
                chk("timeout_err", timeout_err, terr);
`endif
                if (fe) begin
                    outst = 1;
                    age   = 0;
                end
                if (tx_done && outst) outst = 0;
`ifdef UART_TX_FEED_TIMEOUT_EN
                if (outst) begin
                    age++;
                    if (age == TO) begin
                        outst = 0;
                        terr  = 1;
                    end
                end
`endif
                want = idle_c && (lvl_exp > 0);
            end
        end
    end

    // Stimulus sequence
    initial begin
        in_valid = 0; in_data = 0; rst = 1;
        g_rst = 1; g_in_valid = 0; g_in_data = 0; g_tx_done = 0;

        repeat (3) cyc(0, 8'h00, 1);
        chk("reset_level", level, 0);
        chk("reset_frame_en", frame_en, 0);
        chk("reset_data", data_frame, 0);
        chk("reset_busy", busy, 0);
        chk("reset_in_ready", in_ready, 0);
        cyc(0, 8'h00, 0);
        clr_req++;
        cyc(0, 8'h00, 0);
        mon_en = 1;

        // single word latency
        send(8'hA5);
        cyc(0, 8'h00, 0);
        chk("lat_t1_frame_en", frame_en, 0);
        chk("lat_t1_level", level, 1);
        cyc(0, 8'h00, 0);
        chk("lat_t2_frame_en", frame_en, 1);
        chk("lat_t2_data", data_frame, 8'hA5);
        chk("lat_t2_level", level, 0);
        drain();

        // burst to full with a slow transmitter
        tx_auto = 0; tx_fixed = 1;
        for (int i = 0; i < 17; i++) send(8'(i));
        cyc(0, 8'h00, 0);
        chk("burst_full_level", level, 16);
        chk("burst_full_ready", in_ready, 0);
        cyc(1, 8'h11, 0);
        chk("burst_full_ready_hold", in_ready, 0);
        tx_auto = 1;
        send(8'h11);
        drain();
        tx_fixed = 0;

        // push and pop in the same cycle at level 3
        tx_auto = 0;
        for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i));
        cyc(0, 8'h00, 0);
        chk("pp_level_before", level, 3);
        done_req++;
        cyc(1, 8'h77, 0);
        chk("pp_level_push_cycle", level, 3);
        cyc(0, 8'h00, 0);
        chk("pp_frame_en", frame_en, 1);
        chk("pp_level_after", level, 3);
        tx_auto = 1;
        drain();

        // reset while a frame is in flight and four words are queued
        tx_auto = 0;
        for (int i = 0; i < 5; i++) send(8'h40 + 8'(i));
        cyc(0, 8'h00, 0);
        chk("midrst_level_before", level, 4);
        mon_en = 0;
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 1);
        chk("midrst_level", level, 0);
        chk("midrst_frame_en", frame_en, 0);
        chk("midrst_data", data_frame, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        cyc(0, 8'h00, 0);
        done_req++;
        repeat (3) begin
            cyc(0, 8'h00, 0);
            chk("stray_frame_en", frame_en, 0);
            chk("stray_busy", busy, 0);
        end
        exp_q.delete();
        acc_cnt = 0;
        pend = 0;
        clr_req++;
        cyc(0, 8'h00, 0);
        mon_en = 1;
        tx_auto = 1;

        // randomized traffic, covers pointer wrap many times
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 3)) cyc(0, 8'h00, 0);
            send(8'($urandom_range(0, 255)));
        end
        drain();

`ifdef UART_TX_FEED_TIMEOUT_EN
        // transmitter never answers the first word
        tx_auto = 0;
        send(8'h5A);
        send(8'hB4);
        for (int k = 1; k <= 102; k++) begin
            cyc(0, 8'h00, 0);
            if (k == 100) chk("to_not_yet", timeout_err, 0);
            if (k == 101) chk("to_set", timeout_err, 1);
            if (k == 102) begin
                chk("to_next_frame_en", frame_en, 1);
                chk("to_next_data", data_frame, 8'hB4);
            end
        end
        tx_auto = 1;
        drain();
`endif

        // idle gap instance: GAP_CYC = 5
        g_cyc(1, 8'h3C, 0);
        g_cyc(1, 8'hC3, 0);
        g_cyc(0, 8'h00, 0);
        chk("gap_first_frame_en", g_frame_en, 1);
        chk("gap_first_data", g_data_frame, 8'h3C);
        g_cyc(0, 8'h00, 1);
        chk("gap_done_cycle_frame_en", g_frame_en, 0);
        for (int k = 1; k <= 7; k++) begin
            g_cyc(0, 8'h00, k == 3);
            if (k < 7) chk("gap_quiet_frame_en", g_frame_en, 0);
            else begin
                chk("gap_next_frame_en", g_frame_en, 1);
                chk("gap_next_data", g_data_frame, 8'hC3);
            end
        end
        g_cyc(0, 8'h00, 1);
        for (int k = 1; k <= 6; k++) begin
            g_cyc(0, 8'h00, 0);
            chk("gap_tail_frame_en", g_frame_en, 0);
            if (k == 5) chk("gap_busy_last_gap", g_busy, 1);
            if (k == 6) chk("gap_busy_idle", g_busy, 0);
        end
        chk("gap_level_empty", g_level, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
